// File: rtl/vga_timing_gen_pkg.sv
// Shared raster timing constants (default 640x480@60) and sync polarity encodings.
// Pure declarations: no latency, no backpressure.
package vga_timing_gen_pkg;

    localparam logic POL_LOW  = 1'b0;
    localparam logic POL_HIGH = 1'b1;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_CNT_W    = 14;
    localparam int DEF_FRAME_W  = 8;

    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic logic fits_width(input int total, input int w);
        return total <= (1 << w);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with registered sync/blank decoded from the next position.
// Zero latency w.r.t. pos; holds everything while step=0 (wrap is the combinational carry out).
module vga_axis_counter
    import vga_timing_gen_pkg::*;
#(
    parameter int   ACTIVE = DEF_H_ACTIVE,
    parameter int   FP     = DEF_H_FP,
    parameter int   SYNC   = DEF_H_SYNC,
    parameter int   BP     = DEF_H_BP,
    parameter logic POL    = POL_LOW,
    parameter int   W      = DEF_CNT_W
) (
    input  logic         px_clk,
    input  logic         rst,
    input  logic         step,
    output logic [W-1:0] pos,
    output logic         sync,
    output logic         blank,
    output logic         wrap
);

    localparam int           TOTAL   = axis_total(ACTIVE, FP, SYNC, BP);
    // Thresholds are one bit wider so a total of exactly 2**W still compares correctly.
    localparam logic [W:0]   LAST_X  = (W+1)'(TOTAL - 1);
    localparam logic [W:0]   ACT_X   = (W+1)'(ACTIVE);
    localparam logic [W:0]   SS_X    = (W+1)'(ACTIVE + FP);
    localparam logic [W:0]   SE_X    = (W+1)'(ACTIVE + FP + SYNC);
    localparam logic [W-1:0] POS_RST = W'(TOTAL - 1);

    logic         at_last;
    logic [W-1:0] nxt;
    logic         nxt_sync;
    logic         nxt_blank;

    always_comb begin
        at_last   = ({1'b0, pos} == LAST_X);
        nxt       = at_last ? '0 : pos + 1'b1;
        nxt_sync  = ({1'b0, nxt} >= SS_X) && ({1'b0, nxt} < SE_X);
        nxt_blank = ({1'b0, nxt} >= ACT_X);
    end

    assign wrap = step && at_last;

    always_ff @(posedge px_clk or posedge rst) begin
        if (rst) begin
            pos   <= POS_RST;
            sync  <= ~POL;
            blank <= 1'b1;
        end else if (step) begin
            pos   <= nxt;
            sync  <= nxt_sync ? POL : ~POL;
            blank <= nxt_blank;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA/DVI raster timing generator with strobes, line compare and frame counter.
// All outputs registered, zero latency w.r.t. hpos/vpos; raster advances only on edges with ce=1.
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int   H_ACTIVE  = DEF_H_ACTIVE,
    parameter int   H_FP      = DEF_H_FP,
    parameter int   H_SYNC    = DEF_H_SYNC,
    parameter int   H_BP      = DEF_H_BP,
    parameter int   V_ACTIVE  = DEF_V_ACTIVE,
    parameter int   V_FP      = DEF_V_FP,
    parameter int   V_SYNC    = DEF_V_SYNC,
    parameter int   V_BP      = DEF_V_BP,
    parameter logic HSYNC_POL = POL_LOW,
    parameter logic VSYNC_POL = POL_LOW,
    parameter int   CNT_W     = DEF_CNT_W,
    parameter int   FRAME_W   = DEF_FRAME_W
) (
    input  logic               px_clk,
    input  logic               rst,
    input  logic               ce,
    input  logic [CNT_W-1:0]   line_cmp,
    output logic [CNT_W-1:0]   hpos,
    output logic [CNT_W-1:0]   vpos,
    output logic               hsync,
    output logic               vsync,
    output logic               enable,
    output logic               hblank,
    output logic               vblank,
    output logic               line_start,
    output logic               frame_start,
    output logic               line_match,
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam int             H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int             V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam logic [CNT_W:0] H_ACT_X = (CNT_W+1)'(H_ACTIVE);
    localparam logic [CNT_W:0] V_ACT_X = (CNT_W+1)'(V_ACTIVE);

    generate
        if (H_SYNC <= 0 || V_SYNC <= 0 || H_ACTIVE <= 0 || V_ACTIVE <= 0 ||
            !fits_width(H_TOTAL, CNT_W) || !fits_width(V_TOTAL, CNT_W)) begin : g_bad_params
            $error("vga_timing_gen: invalid timing parameters for CNT_W=%0d", CNT_W);
        end
    endgenerate

    logic             h_wrap;
    logic             v_wrap;
    logic [CNT_W-1:0] h_nxt;
    logic [CNT_W-1:0] v_nxt;
    logic             started;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .POL    (HSYNC_POL),
        .W      (CNT_W)
    ) u_h_axis (
        .px_clk (px_clk),
        .rst    (rst),
        .step   (ce),
        .pos    (hpos),
        .sync   (hsync),
        .blank  (hblank),
        .wrap   (h_wrap)
    );

    // The vertical axis steps only on the horizontal carry, so vsync moves at hpos 0 only.
    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .POL    (VSYNC_POL),
        .W      (CNT_W)
    ) u_v_axis (
        .px_clk (px_clk),
        .rst    (rst),
        .step   (h_wrap),
        .pos    (vpos),
        .sync   (vsync),
        .blank  (vblank),
        .wrap   (v_wrap)
    );

    always_comb begin
        h_nxt = h_wrap ? '0 : hpos + 1'b1;
        v_nxt = vpos;
        if (v_wrap) begin
            v_nxt = '0;
        end else if (h_wrap) begin
            v_nxt = vpos + 1'b1;
        end
    end

    // Strobes reload on every edge so they last exactly one px_clk cycle regardless of ce.
    // The (0,0) reached straight out of reset is not a completed frame, hence 'started'.
    always_ff @(posedge px_clk or posedge rst) begin
        if (rst) begin
            enable      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            line_match  <= 1'b0;
            frame_cnt   <= '0;
            started     <= 1'b0;
        end else begin
            line_start  <= h_wrap;
            frame_start <= v_wrap;
            line_match  <= h_wrap && (v_nxt == line_cmp);
            if (ce) begin
                enable  <= ({1'b0, h_nxt} < H_ACT_X) && ({1'b0, v_nxt} < V_ACT_X);
                started <= 1'b1;
            end
            if (v_wrap && started) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

endmodule
